rv32i_mem_responder: RTL and testbench
======================================

# rv32i_mem_responder

Memory-side responder for the rv32i core's load/store path. It accepts one byte-addressed request at a time (LB/LH/LW/LBU/LHU/SB/SH/SW, selected by funct3) and runs it against a 16-bit, synchronous-read, bit-masked BRAM port, splitting word accesses into two half-word beats. It returns a sign- or zero-extended 32-bit result, or a fault, with a single-cycle response strobe. It sits between `rv32i_control` and the RAM `bram_mask` instance.

## Interface
Parameters:
- `XLEN`, 32, request address/data width
- `PORT_LEN`, 16, BRAM data width; fixed at 16 (two byte lanes)
- `ADDR_BITS`, 9, BRAM half-word address width; byte range is 2^(ADDR_BITS+1)

Ports:
- `clk_i` input 1: clock; one clock domain.
- `reset_i` input 1: reset; asynchronous, active-high.
- `req_valid_i` input 1: request present.
- `req_ready_o` output 1: high only in IDLE.
- `req_write_i` input 1: 1 = store, 0 = load.
- `req_funct3_i` input 3: RV32I load/store funct3.
- `req_addr_i` input XLEN: byte address.
- `req_data_i` input XLEN: store data; the low bytes are used for SB/SH.
- `resp_valid_o` output 1: one-cycle completion strobe.
- `resp_data_o` output XLEN: extended load data; 0 for stores and faults.
- `resp_fault_o` output 1: qualified by `resp_valid_o`.
- `mem_addr_o` output ADDR_BITS: half-word address.
- `mem_write_o` output 1: BRAM write enable.
- `mem_mask_o` output PORT_LEN: bit write mask (1 = write).
- `mem_data_o` output PORT_LEN: BRAM write data.
- `mem_data_i` input PORT_LEN: BRAM read data, valid the cycle after the address.

## Operation
- **States:** IDLE, ISSUE0, ISSUE1, FINISH, RESP.
- **Handshake:**
  - A request is accepted on a clock edge where `req_valid_i & req_ready_o`.
  - All request fields are registered at acceptance.
  - Inputs are ignored outside IDLE.
- **Fault check at acceptance** (IDLE → RESP, no BRAM access):
  - funct3 is 011, 110 or 111 (for stores, also 100 and 101);
  - a half-word access with `addr[0]` set;
  - a word access with `addr[1:0]` nonzero.
- **Half-word index:** h = `addr[ADDR_BITS:1]`. Little-endian; lane0 = bits 7:0 = even byte.
- **Byte access:**
  - One beat at h; lane = `addr[0]`.
  - Mask is 16'h00FF for lane0, 16'hFF00 for lane1.
  - Write data is the byte replicated to both lanes.
- **Half-word access:** one beat at h, mask 16'hFFFF.
- **Word access:**
  - Beat0 at h carries bits 15:0; beat1 at h+1 carries bits 31:16.
  - h is even, so h+1 never wraps.
- **Path and data capture:**
  - Narrow: ISSUE0 → FINISH → RESP.
  - Word: ISSUE0 → ISSUE1 → FINISH → RESP.
  - The read of each beat is captured on the edge that leaves the following state.
- **Extension:**
  - LB/LH sign-extend from bit 7 / bit 15.
  - LBU/LHU zero-extend.
  - LW is passed through unchanged.
- **Write strobe:** `mem_write_o` is high only in ISSUE0/ISSUE1 for stores. `mem_mask_o` is 0 whenever `mem_write_o` is low.
- **RESP state:** `resp_valid_o` is high for exactly one cycle, then IDLE.
- **Reset** (including in the middle of a transaction) asynchronously forces IDLE. It aborts any beat in progress and deasserts `mem_write_o` immediately. No response is issued for the aborted request.

## Timing
- **Reset values:**
  - `req_ready_o` = 1.
  - `resp_valid_o`, `resp_fault_o`, `mem_write_o` = 0.
  - `resp_data_o`, `mem_addr_o`, `mem_mask_o`, `mem_data_o` = 0.
- **Latency:** acceptance at edge E0, then `resp_valid_o` is high in:
  - cycle E0+1 for a fault;
  - cycle E0+3 for a narrow access;
  - cycle E0+4 for a word access.
- **Throughput:** at most one request per latency + 1 cycles. There is no acceptance during RESP.
- `resp_data_o` holds its value until the next response. `resp_fault_o` is cleared when the next request is accepted.
- **Store completion:** the BRAM write is complete at the edge that ends ISSUE0 (or ISSUE1 for a word). A load issued next observes the new data.

## Configuration
- **Macro:** `RV32I_MEM_BOUNDS_EN`.
- **Defined:** any request with nonzero `req_addr_i[XLEN-1:ADDR_BITS+1]` faults at acceptance, with no BRAM access.
- **Undefined:** the upper address bits are ignored and addresses alias modulo 2^(ADDR_BITS+1). Such requests never fault on range.

## Structure
- **Package `rv32i_mem_pkg`:**
  - funct3 constants (`F3_LB` … `F3_SW`);
  - state enum;
  - lane mask constants.
- **Sub-module `rv32i_load_extend`** (combinational):
  - inputs: the 32-bit assembled read data, funct3 and `addr[0]`;
  - output: the lane-selected, extended result.
- All other logic is in `rv32i_mem_responder`.

## Test plan
- **SW then LW:**
  - Stimulus: SW 0x8000_1234 @0x10, then LW @0x10.
  - Required: beats h=8 mask FFFF data 1234, then h=9 data 8000; the LW returns 0x8000_1234 at E0+4 with no fault.
- **SB then LB/LBU:**
  - Stimulus: SB 0xA5 @0x11, then LB @0x11 and LBU @0x11.
  - Required: the store is at h=8 with mask FF00 and data A5A5; LB returns 0xFFFF_FFA5 and LBU returns 0x0000_00A5, each at E0+3.
- **Misaligned and illegal requests:**
  - Stimulus: LW @0x12, SH @0x13, and funct3=011.
  - Required: each gives resp at E0+1 with fault=1 and data 0; `mem_write_o` never asserts.
- **Bounds check:**
  - Stimulus: LW @0x400 with `RV32I_MEM_BOUNDS_EN`, then without it.
  - Required: with the macro, fault; without it, the access goes to h=0 and returns the data at 0x0.
- **Reset during a store:**
  - Stimulus: assert `reset_i` during ISSUE1 of an SW.
  - Required: `mem_write_o` drops the same cycle, no resp, `req_ready_o` is 1 after reset, and the next request completes normally.
- **Back-to-back loads:**
  - Stimulus: hold `req_valid_i` high continuously with LH requests.
  - Required: one accept every 4 cycles; `req_ready_o` is low during ISSUE0..RESP.

Source files
------------

// File: rtl/rv32i_mem_responder_pkg.sv
// Shared constants, FSM state type and request legality check for the rv32i memory responder.
package rv32i_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [15:0] MASK_LANE0 = 16'h00FF;
  localparam logic [15:0] MASK_LANE1 = 16'hFF00;
  localparam logic [15:0] MASK_FULL  = 16'hFFFF;

  typedef enum logic [2:0] {
    StIdle,
    StIssue0,
    StIssue1,
    StFinish,
    StResp
  } state_e;

  // Illegal funct3 or misaligned half/word access.
  function automatic logic req_fault(input logic write, input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic f;
    f = 1'b1;
    if (write) begin
      case (funct3)
        F3_SB:   f = 1'b0;
        F3_SH:   f = addr_lo[0];
        F3_SW:   f = |addr_lo;
        default: f = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: f = 1'b0;
        F3_LH, F3_LHU: f = addr_lo[0];
        F3_LW:         f = |addr_lo;
        default:       f = 1'b1;
      endcase
    end
    return f;
  endfunction

endpackage

// File: rtl/rv32i_mem_responder_if.sv
// Request/response handshake between the core load/store path and the memory responder.
interface rv32i_mem_responder_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            req_valid_i;
  logic            req_ready_o;
  logic            req_write_i;
  logic [2:0]      req_funct3_i;
  logic [XLEN-1:0] req_addr_i;
  logic [XLEN-1:0] req_data_i;
  logic            resp_valid_o;
  logic [XLEN-1:0] resp_data_o;
  logic            resp_fault_o;

  modport master (
    output req_valid_i, req_write_i, req_funct3_i, req_addr_i, req_data_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_fault_o
  );

  modport slave (
    input  req_valid_i, req_write_i, req_funct3_i, req_addr_i, req_data_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_fault_o
  );
endinterface

// File: rtl/rv32i_load_extend.sv
// Selects the addressed lane from assembled BRAM read data and sign/zero-extends per funct3.
module rv32i_load_extend
  import rv32i_mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [2:0]  i_funct3,
  input  logic        i_addr0,
  output logic [31:0] o_result
);
  logic [7:0] w_byte;

  assign w_byte = i_addr0 ? i_rdata[15:8] : i_rdata[7:0];

  always_comb begin
    o_result = '0;
    case (i_funct3)
      F3_LB:   o_result = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_result = {{16{i_rdata[15]}}, i_rdata[15:0]};
      F3_LW:   o_result = i_rdata;
      F3_LBU:  o_result = {24'h0, w_byte};
      F3_LHU:  o_result = {16'h0, i_rdata[15:0]};
      default: o_result = '0;
    endcase
  end
endmodule

// File: rtl/rv32i_mem_responder.sv
// Load/store responder onto a 16-bit masked synchronous BRAM; words take two half-word beats.
// Define RV32I_MEM_BOUNDS_EN to fault requests whose address exceeds the BRAM byte range.
module rv32i_mem_responder
  import rv32i_mem_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned PORT_LEN  = 16,
  parameter int unsigned ADDR_BITS = 9
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  rv32i_mem_responder_if.slave bus,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic                 mem_write_o,
  output logic [PORT_LEN-1:0]  mem_mask_o,
  output logic [PORT_LEN-1:0]  mem_data_o,
  input  logic [PORT_LEN-1:0]  mem_data_i
);
  state_e               r_state, w_state_d;
  logic                 r_write;
  logic [2:0]           r_funct3;
  logic [ADDR_BITS:0]   r_addr;
  logic [XLEN-1:0]      r_data;
  logic [PORT_LEN-1:0]  r_lo;
  logic [XLEN-1:0]      r_resp_data;
  logic                 r_resp_fault;

  logic                 w_accept, w_fault, w_oob, w_word;
  logic [ADDR_BITS-1:0] w_h;
  logic [31:0]          w_rdata, w_ext;

`ifdef RV32I_MEM_BOUNDS_EN
  assign w_oob = |bus.req_addr_i[XLEN-1:ADDR_BITS+1];
`else
  logic w_unused_addr;
  assign w_unused_addr = ^bus.req_addr_i[XLEN-1:ADDR_BITS+1];
  assign w_oob         = 1'b0;
`endif

  assign w_fault  = w_oob | req_fault(bus.req_write_i, bus.req_funct3_i, bus.req_addr_i[1:0]);
  assign w_accept = bus.req_valid_i & (r_state == StIdle);
  assign w_h      = r_addr[ADDR_BITS:1];
  assign w_word   = (r_funct3[1:0] == F3_LW[1:0]);
  assign w_rdata  = w_word ? {mem_data_i, r_lo} : {16'h0, mem_data_i};

  rv32i_load_extend u_extend (
    .i_rdata  (w_rdata),
    .i_funct3 (r_funct3),
    .i_addr0  (r_addr[0]),
    .o_result (w_ext)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= StIdle;
    else         r_state <= w_state_d;
  end

  always_comb begin
    w_state_d        = r_state;
    bus.req_ready_o  = 1'b0;
    bus.resp_valid_o = 1'b0;
    mem_addr_o       = '0;
    mem_write_o      = 1'b0;
    mem_mask_o       = '0;
    mem_data_o       = '0;
    unique case (r_state)
      StIdle: begin
        bus.req_ready_o = 1'b1;
        if (bus.req_valid_i) w_state_d = w_fault ? StResp : StIssue0;
      end
      StIssue0: begin
        mem_addr_o  = w_h;
        mem_write_o = r_write;
        if (r_funct3 == F3_SB) begin
          mem_data_o = {2{r_data[7:0]}};
          if (r_write) mem_mask_o = r_addr[0] ? MASK_LANE1 : MASK_LANE0;
        end else begin
          mem_data_o = r_data[15:0];
          if (r_write) mem_mask_o = MASK_FULL;
        end
        w_state_d = w_word ? StIssue1 : StFinish;
      end
      StIssue1: begin
        // Word base h is even, so the upper beat is h with bit 0 set.
        mem_addr_o  = {w_h[ADDR_BITS-1:1], 1'b1};
        mem_write_o = r_write;
        mem_data_o  = r_data[31:16];
        if (r_write) mem_mask_o = MASK_FULL;
        w_state_d   = StFinish;
      end
      StFinish: w_state_d = StResp;
      StResp: begin
        bus.resp_valid_o = 1'b1;
        w_state_d        = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_write      <= 1'b0;
      r_funct3     <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_lo         <= '0;
      r_resp_data  <= '0;
      r_resp_fault <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write      <= bus.req_write_i;
        r_funct3     <= bus.req_funct3_i;
        r_addr       <= bus.req_addr_i[ADDR_BITS:0];
        r_data       <= bus.req_data_i;
        r_resp_fault <= w_fault;
        if (w_fault) r_resp_data <= '0;
      end
      if (r_state == StIssue1) r_lo <= mem_data_i;
      if (r_state == StFinish) r_resp_data <= r_write ? '0 : w_ext;
    end
  end

  assign bus.resp_data_o  = r_resp_data;
  assign bus.resp_fault_o = r_resp_fault;
endmodule

// File: tb/tb_rv32i_mem_responder.sv
// Scoreboard bench for rv32i_mem_responder with a behavioural masked 16-bit synchronous BRAM.
module tb_rv32i_mem_responder;
  import rv32i_mem_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          lat;
    int          acc;
  } resp_t;

  typedef struct {
    logic [8:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
  } beat_t;

  logic        clk;
  logic        rst;
  logic [8:0]  mem_addr;
  logic        mem_write;
  logic [15:0] mem_mask;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] ram [0:511];

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  resp_t resp_q[$];
  beat_t beat_q[$];

  rv32i_mem_responder_if #(.XLEN(32)) bus ();

  rv32i_mem_responder #(
    .XLEN      (32),
    .PORT_LEN  (16),
    .ADDR_BITS (9)
  ) dut (
    .clk_i       (clk),
    .reset_i     (rst),
    .bus         (bus),
    .mem_addr_o  (mem_addr),
    .mem_write_o (mem_write),
    .mem_mask_o  (mem_mask),
    .mem_data_o  (mem_wdata),
    .mem_data_i  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial for (int i = 0; i < 512; i++) ram[i] <= '0;

  always @(posedge clk) begin
    if (mem_write) ram[mem_addr] <= (ram[mem_addr] & ~mem_mask) | (mem_wdata & mem_mask);
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response and write-beat monitor, sampled mid-cycle.
  always @(negedge clk) begin : monitor
    resp_t e;
    beat_t b;
    if (!rst) begin
      if (bus.resp_valid_o) begin
        if (resp_q.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = resp_q.pop_front();
          check("resp_data", bus.resp_data_o, e.data);
          check("resp_fault", {31'b0, bus.resp_fault_o}, {31'b0, e.fault});
          check("resp_latency", cyc - e.acc + 1, e.lat);
        end
      end
      if (mem_write) begin
        if (beat_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          b = beat_q.pop_front();
          check("beat_addr", {23'b0, mem_addr}, {23'b0, b.addr});
          check("beat_mask", {16'b0, mem_mask}, {16'b0, b.mask});
          check("beat_data", {16'b0, mem_wdata}, {16'b0, b.data});
        end
      end else begin
        check("idle_mask", {16'b0, mem_mask}, 32'd0);
      end
    end
  end

  task automatic exp_beat(input logic [8:0] a, input logic [15:0] m, input logic [15:0] d);
    beat_t b;
    b.addr = a;
    b.mask = m;
    b.data = d;
    beat_q.push_back(b);
  endtask

  // lat = 0 means no response is expected.
  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] exp_data,
                       input logic exp_fault, input int lat);
    int    w;
    resp_t e;
    bus.req_write_i  = wr;
    bus.req_funct3_i = f3;
    bus.req_addr_i   = addr;
    bus.req_data_i   = data;
    bus.req_valid_i  = 1'b1;
    w = 0;
    while (!bus.req_ready_o && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!bus.req_ready_o) begin
      check("ready_timeout", 32'd0, 32'd1);
      bus.req_valid_i = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.req_valid_i = 1'b0;
      if (lat > 0) begin
        e.data  = exp_data;
        e.fault = exp_fault;
        e.lat   = lat;
        e.acc   = cyc;
        resp_q.push_back(e);
      end
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (resp_q.size() != 0 && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [31:0] b2b_addr [4];
  logic [31:0] b2b_exp  [4];

  initial begin : stim
    int    n;
    int    last;
    logic  rdy;
    resp_t e;
    b2b_addr = '{32'h10, 32'h12, 32'h10, 32'h12};
    b2b_exp  = '{32'hFFFF_A534, 32'hFFFF_8000, 32'hFFFF_A534, 32'hFFFF_8000};

    rst              = 1'b1;
    bus.req_valid_i  = 1'b0;
    bus.req_write_i  = 1'b0;
    bus.req_funct3_i = '0;
    bus.req_addr_i   = '0;
    bus.req_data_i   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, bus.req_ready_o}, 32'd1);
    check("rst_resp_valid", {31'b0, bus.resp_valid_o}, 32'd0);
    check("rst_resp_fault", {31'b0, bus.resp_fault_o}, 32'd0);
    check("rst_resp_data", bus.resp_data_o, 32'd0);
    check("rst_mem_write", {31'b0, mem_write}, 32'd0);
    check("rst_mem_addr", {23'b0, mem_addr}, 32'd0);
    check("rst_mem_mask", {16'b0, mem_mask}, 32'd0);
    check("rst_mem_data", {16'b0, mem_wdata}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    exp_beat(9'h000, 16'hFFFF, 16'hF00D);
    exp_beat(9'h001, 16'hFFFF, 16'hCAFE);
    issue(1'b1, F3_SW, 32'h0, 32'hCAFE_F00D, 32'h0, 1'b0, 4);
    exp_beat(9'h008, 16'hFFFF, 16'h1234);
    exp_beat(9'h009, 16'hFFFF, 16'h8000);
    issue(1'b1, F3_SW, 32'h10, 32'h8000_1234, 32'h0, 1'b0, 4);
    issue(1'b0, F3_LW, 32'h10, 32'h0, 32'h8000_1234, 1'b0, 4);

    exp_beat(9'h008, 16'hFF00, 16'hA5A5);
    issue(1'b1, F3_SB, 32'h11, 32'h1234_56A5, 32'h0, 1'b0, 3);
    issue(1'b0, F3_LB, 32'h11, 32'h0, 32'hFFFF_FFA5, 1'b0, 3);
    issue(1'b0, F3_LBU, 32'h11, 32'h0, 32'h0000_00A5, 1'b0, 3);
    issue(1'b0, F3_LB, 32'h10, 32'h0, 32'h0000_0034, 1'b0, 3);
    issue(1'b0, F3_LH, 32'h10, 32'h0, 32'hFFFF_A534, 1'b0, 3);
    issue(1'b0, F3_LHU, 32'h12, 32'h0, 32'h0000_8000, 1'b0, 3);

    issue(1'b0, F3_LW, 32'h12, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b1, F3_SH, 32'h13, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
    issue(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b1, 3'b100, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);

`ifdef RV32I_MEM_BOUNDS_EN
    issue(1'b0, F3_LW, 32'h400, 32'h0, 32'h0, 1'b1, 1);
`else
    issue(1'b0, F3_LW, 32'h400, 32'h0, 32'hCAFE_F00D, 1'b0, 4);
`endif
    drain();

    // Abort a word store in its second beat; only the lower half-word lands.
    exp_beat(9'h010, 16'hFFFF, 16'h2222);
    issue(1'b1, F3_SW, 32'h20, 32'h1111_2222, 32'h0, 1'b0, 0);
    @(posedge clk);
    #1;
    check("issue1_write", {31'b0, mem_write}, 32'd1);
    check("issue1_addr", {23'b0, mem_addr}, 32'h11);
    rst = 1'b1;
    #1;
    check("abort_write_drop", {31'b0, mem_write}, 32'd0);
    check("abort_ready", {31'b0, bus.req_ready_o}, 32'd1);
    check("abort_resp_valid", {31'b0, bus.resp_valid_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("after_rst_ready", {31'b0, bus.req_ready_o}, 32'd1);
    issue(1'b0, F3_LW, 32'h20, 32'h0, 32'h0000_2222, 1'b0, 4);
    drain();

    // Back-to-back LH with valid held high.
    bus.req_write_i  = 1'b0;
    bus.req_funct3_i = F3_LH;
    bus.req_data_i   = '0;
    bus.req_addr_i   = b2b_addr[0];
    bus.req_valid_i  = 1'b1;
    n    = 0;
    last = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      rdy = bus.req_ready_o;
      @(posedge clk);
      #1;
      if (rdy) begin
        e.data  = b2b_exp[n];
        e.fault = 1'b0;
        e.lat   = 3;
        e.acc   = cyc;
        resp_q.push_back(e);
        if (n > 0) check("b2b_interval", cyc - last, 32'd4);
        last = cyc;
        n++;
        if (n < 4) bus.req_addr_i = b2b_addr[n];
      end
    end
    bus.req_valid_i = 1'b0;
    check("b2b_accepts", n, 32'd4);
    drain();

    check("resp_q_empty", resp_q.size(), 32'd0);
    check("beat_q_empty", beat_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
